// File: rtl/aes_uart_ctrl.sv
// Sequencer between the UART byte receiver and the AES-128 core: gathers a
// 16-byte block, runs one encrypt/decrypt operation, streams the result back out.
module aes_uart_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rx_valid,
   input  logic [7:0]   rx_data,
   input  logic         work,
   input  logic         enc,
   output logic         aes_start,
   output logic         aes_enc,
   output logic [127:0] aes_din,
   input  logic         aes_done,
   input  logic [127:0] aes_dout,
   output logic         tx_valid,
   output logic [7:0]   tx_data,
   input  logic         tx_ready,
   output logic         busy,
   output logic         overrun,
   output logic         timeout
);

   localparam int unsigned    TW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TERM = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_SEND
   } state_t;

   state_t         state;
   logic [3:0]     cnt;
   logic [TW-1:0]  tcnt;
   logic [127:0]   result;
   logic [3:0]     idx;
   logic [3:0]     idx_nxt;

   assign idx_nxt = idx + 4'd1;

   // NOTE: every register in this block uses <= so all next-state decisions
   // read the values from before the clock edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         tcnt      <= '0;
         idx       <= '0;
         // NOTE: the 128-bit data registers are reset too, so no stale block
         // or half-sent result survives a reset.
         aes_din   <= '0;
         result    <= '0;
         aes_start <= 1'b0;
         aes_enc   <= 1'b1;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         aes_start <= 1'b0;
         timeout   <= 1'b0;
         overrun   <= rx_valid && (state inside {S_START, S_WAIT, S_SEND});

         unique case (state)
            S_IDLE: begin
               if (rx_valid && work) begin
                  aes_din[127:120] <= rx_data;
                  cnt              <= 4'd1;
                  tcnt             <= '0;
                  busy             <= 1'b1;
                  state            <= S_LOAD;
               end
            end

            S_LOAD: begin
               if (!work) begin
                  cnt   <= '0;
                  tcnt  <= '0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (rx_valid) begin
                  // A byte arriving on the terminal count still wins.
                  aes_din[{~cnt, 3'b000} +: 8] <= rx_data;
                  cnt  <= cnt + 4'd1;
                  tcnt <= '0;
                  if (cnt == 4'd15) begin
                     aes_start <= 1'b1;
                     aes_enc   <= enc;
                     state     <= S_START;
                  end
               end else if (tcnt == TERM) begin
                  timeout <= 1'b1;
                  cnt     <= '0;
                  tcnt    <= '0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            S_START: begin
               state <= S_WAIT;
            end

            S_WAIT: begin
               if (aes_done) begin
                  result   <= aes_dout;
                  idx      <= '0;
                  tx_valid <= 1'b1;
                  tx_data  <= aes_dout[127:120];
                  state    <= S_SEND;
               end
            end

            S_SEND: begin
               if (tx_ready) begin
                  if (idx == 4'd15) begin
                     tx_valid <= 1'b0;
                     busy     <= 1'b0;
                     state    <= S_IDLE;
                  end else begin
                     idx     <= idx_nxt;
                     tx_data <= result[{~idx_nxt, 3'b000} +: 8];
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Scoreboard bench for aes_uart_ctrl: a driver pushes expected blocks, an AES
// model answers starts, and a monitor checks every byte leaving the transmitter.
module tb_aes_uart_ctrl;

   localparam int unsigned TO = 100;

   typedef struct {
      logic [127:0] din;
      logic         enc;
   } blk_t;

   logic         clk;
   logic         rst_n;
   logic         rx_valid;
   logic [7:0]   rx_data;
   logic         work;
   logic         enc;
   logic         aes_start;
   logic         aes_enc;
   logic [127:0] aes_din;
   logic         aes_done;
   logic [127:0] aes_dout;
   logic         tx_valid;
   logic [7:0]   tx_data;
   logic         tx_ready;
   logic         busy;
   logic         overrun;
   logic         timeout;

   aes_uart_ctrl #(.TIMEOUT_CYC(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .work      (work),
      .enc       (enc),
      .aes_start (aes_start),
      .aes_enc   (aes_enc),
      .aes_din   (aes_din),
      .aes_done  (aes_done),
      .aes_dout  (aes_dout),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .overrun   (overrun),
      .timeout   (timeout)
   );

   int           total;
   int           bad;
   blk_t         start_q[$];
   logic [7:0]   tx_q[$];
   int           hs_count;
   int           tx_idx;
   int           start_cnt;
   int           ovr_cnt;
   int           to_cnt;
   int           aes_lat;
   bit           fixed_en;
   logic [127:0] fixed_res;
   bit           rand_ready;
   int           stall_left;

   blk_t         m_cur;
   int           m_lat;
   logic [127:0] m_res;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   function automatic logic [127:0] rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic run_block(input logic [127:0] blk, input logic e, input int max_gap);
      blk_t x;
      x.din = blk;
      x.enc = e;
      enc   = e;
      start_q.push_back(x);
      for (int i = 0; i < 16; i++) begin
         send_byte(blk[8*(15-i) +: 8]);
         if (i < 15) repeat ($urandom_range(0, max_gap)) tick();
      end
      check("start_latency", aes_start, 1);
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 3000; i++) begin
         tick();
         if (!busy) break;
      end
      check("idle_within_bound", busy, 0);
      check("tx_all_sent", tx_q.size(), 0);
   endtask

   // AES core model: checks the block at start, answers after a latency.
   initial begin
      aes_done = 1'b0;
      aes_dout = '0;
      forever begin
         @(negedge clk);
         if (rst_n && aes_start) begin
            start_cnt++;
            if (start_q.size() == 0) begin
               check("start_unexpected", 1, 0);
            end else begin
               m_cur = start_q.pop_front();
               check("aes_din", aes_din, m_cur.din);
               check("aes_enc_start", aes_enc, m_cur.enc);
               m_lat = (aes_lat > 0) ? aes_lat : int'($urandom_range(1, 20));
               m_res = fixed_en ? fixed_res : rand_blk();
               repeat (m_lat) @(posedge clk);
               #1;
               aes_done = 1'b1;
               aes_dout = m_res;
               for (int i = 0; i < 16; i++) tx_q.push_back(m_res[8*(15-i) +: 8]);
               @(posedge clk);
               #1;
               aes_done = 1'b0;
               check("done_to_tx_valid", tx_valid, 1);
               check("done_to_tx_byte0", tx_data, m_res[127:120]);
               check("aes_enc_hold", aes_enc, m_cur.enc);
               check("aes_din_hold", aes_din, m_cur.din);
            end
         end
      end
   end

   // Transmit sink: random or fixed readiness, with an optional stall on byte 3.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_left > 0 && tx_valid && tx_idx == 3) begin
            tx_ready = 1'b0;
            stall_left--;
         end else begin
            tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   // Monitor: every presented byte must match the head of the expected queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            tx_idx = 0;
            tx_q.delete();
         end else begin
            if (overrun) ovr_cnt++;
            if (timeout) to_cnt++;
            if (tx_valid) begin
               if (tx_q.size() == 0) begin
                  check("tx_unexpected", 1, 0);
               end else begin
                  check("tx_byte", tx_data, tx_q[0]);
                  if (tx_ready) begin
                     void'(tx_q.pop_front());
                     hs_count++;
                     tx_idx = (tx_idx + 1) % 16;
                  end
               end
            end
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int seen;
      logic [127:0] blk;
      blk_t x;

      rst_n      = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = '0;
      work       = 1'b0;
      enc        = 1'b0;
      stall_left = 0;
      rand_ready = 1'b0;
      aes_lat    = 0;
      fixed_en   = 1'b0;
      fixed_res  = '0;
      tick();
      tick();
      check("rst_aes_start", aes_start, 0);
      check("rst_aes_enc", aes_enc, 1);
      check("rst_aes_din", aes_din, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout", timeout, 0);
      rst_n = 1'b1;
      tick();

      // Basic encrypt with the known vector.
      work      = 1'b1;
      fixed_en  = 1'b1;
      fixed_res = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      run_block(128'h00112233445566778899aabbccddeeff, 1'b1, 0);
      wait_idle();
      fixed_en = 1'b0;

      // Decrypt, enc flipped during WAIT, 5-cycle stall on byte 3.
      aes_lat    = 15;
      stall_left = 5;
      base       = hs_count;
      run_block(rand_blk(), 1'b0, 1);
      tick();
      enc = 1'b1;
      wait_idle();
      check("stall_handshakes", hs_count - base, 16);
      check("stall_consumed", stall_left, 0);
      aes_lat = 0;

      // Work gating: ignored bytes, then an aborted partial block.
      work = 1'b0;
      base = start_cnt;
      for (int i = 0; i < 20; i++) send_byte(8'($urandom));
      check("gated_busy", busy, 0);
      work = 1'b1;
      send_byte(8'($urandom));
      check("busy_load", busy, 1);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom));
      work = 1'b0;
      tick();
      tick();
      check("abort_busy", busy, 0);
      check("gated_no_start", start_cnt - base, 0);
      work = 1'b1;
      run_block(rand_blk(), 1'b1, 2);
      wait_idle();

      // Inter-byte timeout after 5 bytes.
      base = to_cnt;
      for (int i = 0; i < 5; i++) send_byte(8'($urandom));
      seen = 0;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (timeout) begin
            seen = k;
            break;
         end
      end
      check("timeout_delay", seen, TO);
      check("timeout_busy", busy, 0);
      tick();
      check("timeout_count", to_cnt - base, 1);

      // A byte arriving just before the limit keeps the block alive.
      blk   = rand_blk();
      x.din = blk;
      x.enc = 1'b0;
      enc   = 1'b0;
      start_q.push_back(x);
      for (int i = 0; i < 5; i++) send_byte(blk[8*(15-i) +: 8]);
      repeat (TO - 2) tick();
      for (int i = 5; i < 16; i++) send_byte(blk[8*(15-i) +: 8]);
      check("late_byte_start", aes_start, 1);
      wait_idle();
      check("late_byte_no_timeout", to_cnt - base, 1);

      // Overrun: 3 bytes in WAIT, 2 in SEND.
      rand_ready = 1'b1;
      aes_lat    = 12;
      base       = ovr_cnt;
      run_block(rand_blk(), 1'b1, 0);
      repeat (3) begin
         tick();
         send_byte(8'($urandom));
      end
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (tx_valid) begin
            seen = 1;
            break;
         end
         tick();
      end
      check("send_reached", seen, 1);
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      wait_idle();
      check("overrun_count", ovr_cnt - base, 5);
      aes_lat = 0;
      run_block(rand_blk(), 1'b0, 1);
      wait_idle();

      // Random traffic.
      for (int n = 0; n < 4; n++) begin
         run_block(rand_blk(), 1'($urandom_range(0, 1)), 3);
         wait_idle();
      end

      // Reset in the middle of SEND.
      rand_ready = 1'b0;
      base       = hs_count;
      run_block(rand_blk(), 1'b0, 0);
      for (int i = 0; i < 500 && hs_count < base + 6; i++) tick();
      check("rst_send_hs", hs_count - base, 6);
      rst_n = 1'b0;
      #1;
      check("midrst_tx_valid", tx_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_aes_enc", aes_enc, 1);
      tick();
      rst_n = 1'b1;
      tick();
      run_block(rand_blk(), 1'b1, 1);
      wait_idle();

      check("start_q_empty", start_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
